// File: rtl/color_pkg.sv
// color_pkg: colour codes, channel enum and TCS3200 filter selects shared by the scan path and sort FSM.
package color_pkg;
  localparam int FREQ_W = 10;
  localparam logic [1:0] COLOR_NONE  = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;
  localparam logic [1:0] FILT_RED    = 2'b00;
  localparam logic [1:0] FILT_GREEN  = 2'b11;
  localparam logic [1:0] FILT_BLUE   = 2'b01;
  localparam logic [1:0] FILT_CLEAR  = 2'b10;
  typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE, CH_CLEAR} ch_t;
  function automatic logic [1:0] filt_sel(input ch_t c);
    return c == CH_RED ? FILT_RED : c == CH_GREEN ? FILT_GREEN : c == CH_BLUE ? FILT_BLUE : FILT_CLEAR;
  endfunction
endpackage

// File: rtl/color_scan_ctrl_if.sv
// color_scan_ctrl_if: sort-FSM and frequency-counter signals of the colour scan sequencer.
// COLOR_SCAN_CLEAR_EN adds the ClearFreq result.
interface color_scan_ctrl_if;
  import color_pkg::*;
  logic              Go;
  logic              CntFinished;
  logic [FREQ_W-1:0] CntFreq;
  logic              CntStart;
  logic              S2;
  logic              S3;
  logic [FREQ_W-1:0] RedFreq;
  logic [FREQ_W-1:0] GreenFreq;
  logic [FREQ_W-1:0] BlueFreq;
`ifdef COLOR_SCAN_CLEAR_EN
  logic [FREQ_W-1:0] ClearFreq;
`endif
  logic [1:0]        Color;
  logic              Valid;
  logic              Busy;
  logic              Error;
  modport slave (
    input  Go, CntFinished, CntFreq,
    output CntStart, S2, S3, RedFreq, GreenFreq, BlueFreq,
`ifdef COLOR_SCAN_CLEAR_EN
    output ClearFreq,
`endif
    output Color, Valid, Busy, Error
  );
  modport master (
    output Go, CntFinished, CntFreq,
    input  CntStart, S2, S3, RedFreq, GreenFreq, BlueFreq,
`ifdef COLOR_SCAN_CLEAR_EN
    input  ClearFreq,
`endif
    input  Color, Valid, Busy, Error
  );
endinterface

// File: rtl/color_classify.sv
// color_classify: dominant-colour pick (ties R>G>B) with dim reject; COLOR_SCAN_CLEAR_EN adds the ambient/white reject.
module color_classify
  import color_pkg::*;
#(
  parameter logic [FREQ_W-1:0] MIN_LEVEL = 10'd20
) (
  input  logic [FREQ_W-1:0] red,
  input  logic [FREQ_W-1:0] green,
  input  logic [FREQ_W-1:0] blue,
`ifdef COLOR_SCAN_CLEAR_EN
  input  logic [FREQ_W-1:0] clear,
`endif
  output logic [1:0]        color
);
  logic              r_win, g_win, dim;
  logic [FREQ_W-1:0] peak;
  logic [1:0]        pick;
  assign r_win = red >= green && red >= blue;
  assign g_win = green >= blue;
  assign peak  = r_win ? red : g_win ? green : blue;
  assign pick  = r_win ? COLOR_RED : g_win ? COLOR_GREEN : COLOR_BLUE;
`ifdef COLOR_SCAN_CLEAR_EN
  // a strong clear channel relative to the peak means white or ambient light
  assign dim   = peak < MIN_LEVEL || {peak, 2'b00} < {2'b00, clear};
`else
  assign dim   = peak < MIN_LEVEL;
`endif
  assign color = dim ? COLOR_NONE : pick;
endmodule

// File: rtl/color_scan_ctrl.sv
// color_scan_ctrl: steps TCS3200 filters R,G,B (and CLEAR with COLOR_SCAN_CLEAR_EN), runs one counter
// window per channel, then publishes the counts and dominant colour with a Valid pulse.
module color_scan_ctrl
  import color_pkg::*;
#(
  parameter int                SETTLE_CYCLES  = 100_000,
  parameter int                TIMEOUT_CYCLES = 8_000_000,
  parameter logic [FREQ_W-1:0] MIN_LEVEL      = 10'd20
) (
  input logic               CLK,
  input logic               RST_N,
  color_scan_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, CAPTURE, CLASSIFY} state_t;
`ifdef COLOR_SCAN_CLEAR_EN
  localparam ch_t CH_LAST = CH_CLEAR;
`else
  localparam ch_t CH_LAST = CH_BLUE;
`endif
  state_t            state, state_n;
  ch_t               ch, ch_n;
  logic [31:0]       cnt, cnt_n;
  logic              err, err_n, valid;
  logic [FREQ_W-1:0] r_cap, g_cap, b_cap, r_out, g_out, b_out;
  logic [1:0]        color_c, color_q;
  logic              cap;
`ifdef COLOR_SCAN_CLEAR_EN
  logic [FREQ_W-1:0] c_cap, c_out;
`endif
  assign cap = state == MEASURE && bus.CntFinished;
  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt + 32'd1;
    err_n   = err;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.Go) begin
          state_n = SETTLE;
          ch_n    = CH_RED;
          err_n   = 1'b0;
        end
      end
      SETTLE: if (cnt == 32'(SETTLE_CYCLES - 1)) begin
        state_n = MEASURE;
        cnt_n   = '0;
      end
      MEASURE: begin
        if (bus.CntFinished) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          err_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      CAPTURE: begin
        cnt_n   = '0;
        state_n = ch == CH_LAST ? CLASSIFY : SETTLE;
        ch_n    = ch == CH_LAST ? ch : ch_t'(ch + 2'd1);
      end
      CLASSIFY: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ch    <= CH_RED;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end
  // raw captures stay internal so published results change only together with Valid
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cap   <= '0;
      g_cap   <= '0;
      b_cap   <= '0;
      r_out   <= '0;
      g_out   <= '0;
      b_out   <= '0;
      color_q <= COLOR_NONE;
      valid   <= 1'b0;
    end else begin
      if (cap && ch == CH_RED) r_cap <= bus.CntFreq;
      if (cap && ch == CH_GREEN) g_cap <= bus.CntFreq;
      if (cap && ch == CH_BLUE) b_cap <= bus.CntFreq;
      if (state == CLASSIFY) begin
        r_out   <= r_cap;
        g_out   <= g_cap;
        b_out   <= b_cap;
        color_q <= color_c;
      end
      valid <= state == CLASSIFY;
    end
  end
`ifdef COLOR_SCAN_CLEAR_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_cap <= '0;
      c_out <= '0;
    end else begin
      if (cap && ch == CH_CLEAR) c_cap <= bus.CntFreq;
      if (state == CLASSIFY) c_out <= c_cap;
    end
  end
  assign bus.ClearFreq = c_out;
`endif
  color_classify #(.MIN_LEVEL(MIN_LEVEL)) u_classify (
    .red   (r_cap),
    .green (g_cap),
    .blue  (b_cap),
`ifdef COLOR_SCAN_CLEAR_EN
    .clear (c_cap),
`endif
    .color (color_c)
  );
  assign bus.CntStart  = state == MEASURE;
  assign {bus.S2, bus.S3} = state == IDLE ? 2'b00 : filt_sel(ch);
  assign bus.Busy      = state != IDLE;
  assign bus.Error     = err;
  assign bus.Valid     = valid;
  assign bus.RedFreq   = r_out;
  assign bus.GreenFreq = g_out;
  assign bus.BlueFreq  = b_out;
  assign bus.Color     = color_q;
endmodule

// File: tb/tb_color_scan_ctrl.sv
// tb_color_scan_ctrl: directed checks of color_scan_ctrl against a behavioural frequency-counter model.
module tb_color_scan_ctrl;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  color_scan_ctrl_if bus();
  color_scan_ctrl #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );
  always #5 CLK = ~CLK;
  logic [9:0] mr, mg, mb, mc;
  logic       mute_green = 1'b0;
  int         wcnt;
  // counter model: finishes 3 cycles into the window, holds the result until CntStart drops
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wcnt <= 0;
      bus.CntFinished <= 1'b0;
      bus.CntFreq <= '0;
    end else if (!bus.CntStart) begin
      wcnt <= 0;
      bus.CntFinished <= 1'b0;
    end else begin
      wcnt <= wcnt + 1;
      if (wcnt == 2 && !(mute_green && {bus.S2, bus.S3} == 2'b11)) begin
        bus.CntFinished <= 1'b1;
        case ({bus.S2, bus.S3})
          2'b00: bus.CntFreq <= mr;
          2'b11: bus.CntFreq <= mg;
          2'b01: bus.CntFreq <= mb;
          default: bus.CntFreq <= mc;
        endcase
      end
    end
  end
  logic [1:0] seq [8];
  int sidx, vcnt, run, last_run, low, min_low;
  logic prev_cs = 1'b0;
  always @(negedge CLK) begin
    if (bus.CntStart && !prev_cs) begin
      if (sidx > 0 && low < min_low) min_low = low;
      if (sidx < 8) seq[sidx] = {bus.S2, bus.S3};
      sidx = sidx + 1;
    end
    if (bus.CntStart) begin
      run = run + 1;
      low = 0;
    end else begin
      if (prev_cs) last_run = run;
      run = 0;
      low = low + 1;
    end
    if (bus.Valid) vcnt = vcnt + 1;
    prev_cs = bus.CntStart;
  end
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic clr_obs();
    sidx = 0;
    vcnt = 0;
    min_low = 99;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.Busy && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_bound", 32'(n < 3000), 1);
    @(negedge CLK);
  endtask
  task automatic scan(input logic [9:0] r, g, b, c);
    mr = r; mg = g; mb = b; mc = c;
    @(negedge CLK);
    clr_obs();
    bus.Go = 1'b1;
    @(negedge CLK);
    bus.Go = 1'b0;
    wait_idle();
  endtask
  initial begin
    int n;
    bus.Go = 1'b0;
    mr = '0; mg = '0; mb = '0; mc = '0;
    clr_obs();
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_cntstart", 32'(bus.CntStart), 0);
    chk("rst_s2s3", 32'({bus.S2, bus.S3}), 0);
    chk("rst_color", 32'(bus.Color), 0);
    chk("rst_red", 32'(bus.RedFreq), 0);
    chk("rst_valid", 32'(bus.Valid), 0);
    chk("rst_error", 32'(bus.Error), 0);
    RST_N = 1'b1;
    // basic scan: filter order, one Valid, results and colour
    scan(10'd300, 10'd120, 10'd90, 10'd0);
    chk("t1_windows", 32'(sidx), 3);
    chk("t1_filt0", 32'(seq[0]), 0);
    chk("t1_filt1", 32'(seq[1]), 3);
    chk("t1_filt2", 32'(seq[2]), 1);
    chk("t1_valid", 32'(vcnt), 1);
    chk("t1_red", 32'(bus.RedFreq), 300);
    chk("t1_green", 32'(bus.GreenFreq), 120);
    chk("t1_blue", 32'(bus.BlueFreq), 90);
    chk("t1_color", 32'(bus.Color), 1);
    chk("t1_busy", 32'(bus.Busy), 0);
    chk("t1_gap", 32'(min_low), 5);
    // classification corners
    scan(10'd200, 10'd200, 10'd50, 10'd0);
    chk("t2_tie_red", 32'(bus.Color), 1);
    scan(10'd5, 10'd15, 10'd10, 10'd0);
    chk("t2_dim", 32'(bus.Color), 0);
    chk("t2_dim_green", 32'(bus.GreenFreq), 15);
    scan(10'd50, 10'd60, 10'd61, 10'd0);
    chk("t2_blue", 32'(bus.Color), 3);
    scan(10'd50, 10'd61, 10'd61, 10'd0);
    chk("t2_tie_green", 32'(bus.Color), 2);
    scan(10'd20, 10'd19, 10'd0, 10'd0);
    chk("t2_min_edge", 32'(bus.Color), 1);
    // green window never finishes: timeout
    mute_green = 1'b1;
    scan(10'd400, 10'd1, 10'd1, 10'd0);
    chk("t3_error", 32'(bus.Error), 1);
    chk("t3_no_valid", 32'(vcnt), 0);
    chk("t3_cntstart", 32'(bus.CntStart), 0);
    chk("t3_window_len", 32'(last_run), 50);
    chk("t3_red_held", 32'(bus.RedFreq), 20);
    mute_green = 1'b0;
    scan(10'd300, 10'd120, 10'd90, 10'd0);
    chk("t3_error_clr", 32'(bus.Error), 0);
    chk("t3_valid", 32'(vcnt), 1);
    chk("t3_color", 32'(bus.Color), 1);
    // asynchronous reset during the blue window
    mr = 10'd300; mg = 10'd120; mb = 10'd90;
    @(negedge CLK);
    bus.Go = 1'b1;
    @(negedge CLK);
    bus.Go = 1'b0;
    n = 0;
    while (!({bus.S2, bus.S3} == 2'b01 && bus.CntStart) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("t4_reach_blue", 32'(n < 500), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("t4_cntstart", 32'(bus.CntStart), 0);
    chk("t4_busy", 32'(bus.Busy), 0);
    chk("t4_s2s3", 32'({bus.S2, bus.S3}), 0);
    chk("t4_red", 32'(bus.RedFreq), 0);
    chk("t4_color", 32'(bus.Color), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    // Go held high for the whole scan, dropped as soon as it ends
    mr = 10'd10; mg = 10'd400; mb = 10'd399;
    @(negedge CLK);
    clr_obs();
    bus.Go = 1'b1;
    @(negedge CLK);
    n = 0;
    while (bus.Busy && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    bus.Go = 1'b0;
    chk("t5_bound", 32'(n < 3000), 1);
    repeat (3) @(negedge CLK);
    chk("t5_valid", 32'(vcnt), 1);
    chk("t5_windows", 32'(sidx), 3);
    chk("t5_gap", 32'(min_low), 5);
    chk("t5_color", 32'(bus.Color), 2);
    chk("t5_idle", 32'(bus.Busy), 0);
`ifdef COLOR_SCAN_CLEAR_EN
    scan(10'd100, 10'd60, 10'd40, 10'd500);
    chk("t6_windows", 32'(sidx), 4);
    chk("t6_filt3", 32'(seq[3]), 2);
    chk("t6_clear", 32'(bus.ClearFreq), 500);
    chk("t6_color", 32'(bus.Color), 0);
    scan(10'd100, 10'd60, 10'd40, 10'd400);
    chk("t6_color_ok", 32'(bus.Color), 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
